// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display
//   (MM.SS layout). Scans the four BCD digits one at a time. In adjust mode
//   the selected field (minutes or seconds) blinks at a parameterised rate.
//   All outputs are registered and active-low.
//
// Parameters
//   REFRESH_DIV : clk cycles each digit is held (>= 2)
//   BLINK_DIV   : clk cycles per blink-phase toggle (>= 2)
//
// Ports
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   min_tens  in   [3:0] minutes tens digit (BCD)
//   min_ones  in   [3:0] minutes ones digit (BCD)
//   sec_tens  in   [3:0] seconds tens digit (BCD)
//   sec_ones  in   [3:0] seconds ones digit (BCD)
//   adj       in   adjust mode, enables blinking of the selected field
//   sel       in   field select: 0 = minutes (digits 3:2), 1 = seconds (1:0)
//   an        out  [3:0] digit anodes, active-low (an[0] = sec_ones)
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp        out  decimal point, active-low, lit on digit 2 only
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  logic [REF_W-1:0] refresh_cnt;
  logic             tick;
  logic [BLK_W-1:0] blink_cnt;
  logic             phase;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic             in_field;
  logic             blank;
  logic [3:0]       digit;
  logic [6:0]       seg_dec;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  // Refresh timer: one tick per digit slot.
  assign tick = (refresh_cnt == REF_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Blink timer only runs in adjust mode, so every adjust session starts
  // with the field visible for a full BLINK_DIV period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!adj) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // idx resets to 3 so the first load after reset lands on digit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= 2'd3;
    end else if (tick) begin
      idx <= idx_next;
    end
  end

  assign idx_next = idx + 2'd1;

  // Minutes live on digits 3:2 (idx_next[1] = 1), seconds on 1:0.
  // Blanking looks at the registered phase, i.e. its value before the edge.
  assign in_field = sel ? ~idx_next[1] : idx_next[1];
  assign blank    = adj & phase & in_field;

  always_comb begin
    digit = sec_ones;
    case (idx_next)
      2'd0: digit = sec_ones;
      2'd1: digit = sec_tens;
      2'd2: digit = min_ones;
      2'd3: digit = min_tens;
      default: digit = sec_ones;
    endcase
  end

  always_comb begin
    seg_dec = SEG_DASH;
    case (digit)
      4'd0: seg_dec = SEG_0;
      4'd1: seg_dec = SEG_1;
      4'd2: seg_dec = SEG_2;
      4'd3: seg_dec = SEG_3;
      4'd4: seg_dec = SEG_4;
      4'd5: seg_dec = SEG_5;
      4'd6: seg_dec = SEG_6;
      4'd7: seg_dec = SEG_7;
      4'd8: seg_dec = SEG_8;
      4'd9: seg_dec = SEG_9;
      default: seg_dec = SEG_DASH;
    endcase
  end

  always_comb begin
    an_next  = 4'b1111;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (!blank) begin
      case (idx_next)
        2'd0: an_next = 4'b1110;
        2'd1: an_next = 4'b1101;
        2'd2: an_next = 4'b1011;
        2'd3: an_next = 4'b0111;
        default: an_next = 4'b1111;
      endcase
      seg_next = seg_dec;
      dp_next  = (idx_next == 2'd2) ? 1'b0 : 1'b1;
    end
  end

  // Outputs only change on a load edge, so nothing glitches between slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (tick) begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       adj;
  logic       sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int   checks;
  int   failures;
  exp_t sb[$];

  seven_seg_scanner #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .adj     (adj),
    .sel     (sel),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0111111;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  function automatic exp_t mk_off();
    exp_t e;
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    e.dp  = 1'b1;
    return e;
  endfunction

  // Expected display for slot i given the inputs currently driven.
  function automatic exp_t mk(input int i, input bit blank);
    exp_t       e;
    logic [3:0] d;
    e = mk_off();
    d = sec_ones;
    if (!blank) begin
      case (i)
        0: begin d = sec_ones; e.an = 4'b1110; end
        1: begin d = sec_tens; e.an = 4'b1101; end
        2: begin d = min_ones; e.an = 4'b1011; end
        3: begin d = min_tens; e.an = 4'b0111; end
        default: begin d = sec_ones; e.an = 4'b1111; end
      endcase
      e.seg = seg_of(d);
      e.dp  = (i == 2) ? 1'b0 : 1'b1;
    end
    return e;
  endfunction

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty, got an=%b seg=%b dp=%b", tag, an, seg, dp);
    end else begin
      e = sb.pop_front();
      assert ({an, seg, dp} === {e.an, e.seg, e.dp}) else begin
        failures++;
        $error("FAIL %s got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
               tag, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic push_slot(input int i, input bit blank);
    exp_t e;
    e = mk(i, blank);
    repeat (4) sb.push_back(e);
  endtask

  // One full digit slot: load edge plus three hold edges.
  task automatic run_slot(input int i, input bit blank, input string tag);
    push_slot(i, blank);
    repeat (4) begin
      advance();
      check(tag);
    end
  endtask

  task automatic off_edges(input int n, input string tag);
    repeat (n) begin
      sb.push_back(mk_off());
      advance();
      check(tag);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    min_tens = 4'd5;
    min_ones = 4'd9;
    sec_tens = 4'd0;
    sec_ones = 4'd3;
    adj      = 1'b0;
    sel      = 1'b0;

    // Reset held
    advance();
    advance();
    sb.push_back(mk_off());
    check("reset_hold");

    // Release: three all-off edges, digit 0 on the fourth
    reset_n = 1'b1;
    off_edges(3, "post_release");

    // Two frames of the plain scan
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++)
        run_slot(i, 1'b0, "scan");

    // Invalid digit shows a dash; mid-slot input change has no effect
    sec_ones = 4'hC;
    push_slot(0, 1'b0);
    advance(); check("invalid_dash");
    advance(); check("invalid_dash");
    sec_ones = 4'd3;
    advance(); check("invalid_hold");
    advance(); check("invalid_hold");
    for (int i = 1; i < 4; i++) run_slot(i, 1'b0, "scan_after_invalid");
    for (int i = 0; i < 4; i++) run_slot(i, 1'b0, "resample");

    // Blink minutes: adj rises at a frame start
    adj = 1'b1;
    sel = 1'b0;
    run_slot(0, 1'b0, "blink_min_sec0");
    run_slot(1, 1'b0, "blink_min_sec1");
    run_slot(2, 1'b1, "blink_min_off2");
    run_slot(3, 1'b1, "blink_min_off3");
    run_slot(0, 1'b0, "blink_min_sec0b");
    run_slot(1, 1'b0, "blink_min_sec1b");
    run_slot(2, 1'b1, "blink_min_off2b");
    run_slot(3, 1'b1, "blink_min_off3b");

    // Adjust off: everything visible again
    adj = 1'b0;
    sel = 1'b1;
    run_slot(0, 1'b0, "adj_off0");
    run_slot(1, 1'b0, "adj_off1");

    // Blink seconds, then drop adj while blanked
    adj = 1'b1;
    run_slot(2, 1'b0, "blink_sec_min2");
    run_slot(3, 1'b0, "blink_sec_min3");
    push_slot(0, 1'b1);
    advance(); check("blink_sec_off0");
    advance(); check("blink_sec_off0");
    adj = 1'b0;
    advance(); check("blank_held");
    advance(); check("blank_held");
    run_slot(1, 1'b0, "adj_drop_visible1");

    // Mid-scan reset while digit 2 is displayed
    push_slot(2, 1'b0);
    advance(); check("pre_reset_dig2");
    advance(); check("pre_reset_dig2");
    sb.delete();
    reset_n = 1'b0;
    #1;
    sb.push_back(mk_off());
    check("async_reset");
    off_edges(2, "reset_mid_hold");
    reset_n = 1'b1;
    off_edges(3, "restart_off");
    run_slot(0, 1'b0, "restart_dig0");
    run_slot(1, 1'b0, "restart_dig1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
